// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multi-cycle RV32I sequencer:
// FSM states, fault causes and opcode constants.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    FAULT     = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // True for every opcode the sequencer knows how to run.
  function automatic logic op_legal(input logic [6:0] op);
    logic v;
    v = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_REG: v = 1'b1;
      default:        v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Shared instruction/data memory port between the
// sequencer (master) and the memory (slave).
interface multicycle_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_sequencer_wait_timer.sv
// Counts consecutive un-acknowledged memory cycles and
// flags a timeout on the last allowed cycle.
module seq_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  localparam int CW =
    (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam logic EN = (WAIT_LIMIT != 0);

  logic [CW-1:0] r_cnt;

  // Wait counter: cleared on any state change, else counts stalls.
  always_ff @(posedge clk) begin
    if (reset || clear)
      r_cnt <= '0;
    else if (active && !ready)
      r_cnt <= r_cnt + 1'b1;
  end

  assign timeout = EN && active && !ready && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM driving one shared memory
// port, phase strobes, retire counting and fault trapping.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int COUNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  multicycle_sequencer_if.master mem,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic               retired,
  output logic [COUNT_W-1:0] retire_count,
  output logic [2:0]         state,
  output logic               fault,
  output logic [1:0]         fault_cause
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  fault_t            r_cause;
  logic [COUNT_W-1:0] r_count;
  logic              w_timeout;
  logic              w_active;
  logic              w_is_mem;
  logic              w_is_store;

  assign w_is_store = (op == OP_STORE);
  assign w_is_mem   = (op == OP_LOAD) || w_is_store;
  assign w_active   = (r_state == FETCH) || (r_state == MEM);

  seq_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_next != r_state),
    .active  (w_active),
    .ready   (mem.mem_ready),
    .timeout (w_timeout)
  );

  // Next-state selection for every phase.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FETCH: begin
        if (mem.mem_ready)  w_next = DECODE;
        else if (w_timeout) w_next = FAULT;
      end
      DECODE: begin
        w_next = op_legal(op) ? EXECUTE : FAULT;
      end
      EXECUTE: begin
        if (op == OP_BRANCH) w_next = FETCH;
        else if (w_is_mem)   w_next = MEM;
        else                 w_next = WRITEBACK;
      end
      MEM: begin
        if (mem.mem_ready)
          w_next = w_is_store ? FETCH : WRITEBACK;
        else if (w_timeout)
          w_next = FAULT;
      end
      WRITEBACK: w_next = FETCH;
      FAULT:     w_next = FAULT;
      default:   w_next = FETCH;
    endcase
  end

  // State, sticky fault cause and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_cause <= FAULT_NONE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == FAULT && r_state != FAULT)
        r_cause <= (r_state == DECODE) ?
                   FAULT_ILLEGAL : FAULT_TIMEOUT;
      if (retired)
        r_count <= r_count + 1'b1;
    end
  end

  // Strobes decoded straight from state, op and mem_ready.
  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_we       = 1'b0;
    mem.mem_addr_sel = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    retired          = 1'b0;
    unique case (r_state)
      FETCH: begin
        mem.mem_req = 1'b1;
        ir_write    = mem.mem_ready;
      end
      EXECUTE: begin
        if (op == OP_BRANCH) begin
          pc_write = 1'b1;
          retired  = 1'b1;
        end
      end
      MEM: begin
        mem.mem_req      = 1'b1;
        mem.mem_addr_sel = 1'b1;
        mem.mem_we       = w_is_store;
        if (mem.mem_ready && w_is_store) begin
          pc_write = 1'b1;
          retired  = 1'b1;
        end
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retired   = 1'b1;
      end
      default: ;
    endcase
  end

  assign state        = r_state;
  assign fault        = (r_state == FAULT);
  assign fault_cause  = r_cause;
  assign retire_count = r_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer
// plus directed fault, timeout and sequence checks.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  typedef struct {
    int lat;
    int rw;
    int we;
    int asel;
    int req;
  } exp_t;

  localparam int N = 150;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  op;
  logic        ir_write, pc_write, reg_write, retired;
  logic [31:0] retire_count;
  logic [2:0]  state;
  logic        fault;
  logic [1:0]  fault_cause;

  bit          mode = 1'b0;
  logic        mr_rsp = 1'b0;
  logic        mr_man = 1'b0;
  logic [6:0]  op_rsp = 7'd0;
  logic [6:0]  op_man = 7'd0;

  logic [6:0]  opq[$];
  int          waitq[$];
  exp_t        sb[$];
  logic [6:0]  ops[9];

  int checks = 0;
  int errors = 0;

  multicycle_sequencer_if mif();

  assign mif.mem_ready = (mode == 1'b0) ? mr_rsp : mr_man;
  assign op = (mode == 1'b0) ? op_rsp : op_man;

  multicycle_sequencer #(
    .WAIT_LIMIT (16),
    .COUNT_W    (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .mem          (mif),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .retired      (retired),
    .retire_count (retire_count),
    .state        (state),
    .fault        (fault),
    .fault_cause  (fault_cause)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, longint act,
                              longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endfunction

  // Reference: per-instruction totals from the latency table.
  function automatic exp_t model(logic [6:0] o, int fw,
                                 int mw);
    exp_t e;
    bit   m;
    m = (o == OP_LOAD) || (o == OP_STORE);
    e.lat = (o == OP_BRANCH) ? 3 :
            (o == OP_LOAD)   ? 5 : 4;
    e.lat += fw + (m ? mw : 0);
    e.rw   = (o == OP_BRANCH || o == OP_STORE) ? 0 : 1;
    e.we   = (o == OP_STORE) ? mw + 1 : 0;
    e.asel = m ? mw + 1 : 0;
    e.req  = fw + 1 + e.asel;
    return e;
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    mr_man = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Memory responder: waits the planned number of cycles.
  initial begin
    int         w;
    bit         have;
    bit         ld;
    logic [6:0] pend;
    have = 0;
    ld   = 0;
    w    = 0;
    pend = 7'd0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || mode != 1'b0) begin
        have   = 0;
        ld     = 0;
        mr_rsp = 1'b0;
      end else begin
        if (ld) begin
          op_rsp = pend;
          ld     = 0;
        end
        mr_rsp = 1'b0;
        if (mif.mem_req) begin
          if (!have && waitq.size() > 0) begin
            w    = waitq.pop_front();
            have = 1;
          end
          if (have) begin
            if (w == 0) begin
              mr_rsp = 1'b1;
              have   = 0;
              if (!mif.mem_addr_sel && opq.size() > 0) begin
                pend = opq.pop_front();
                ld   = 1;
              end
            end else begin
              w--;
            end
          end
        end
      end
    end
  end

  // Monitor: accumulates strobes, checks on each retire.
  initial begin
    int   cyc, a_rw, a_we, a_as, a_rq, a_ir, a_pc, nret;
    bit   a_fl;
    exp_t e;
    cyc = 0; a_rw = 0; a_we = 0; a_as = 0; a_rq = 0;
    a_ir = 0; a_pc = 0; a_fl = 0; nret = 0;
    forever begin
      @(negedge clk);
      if (reset || mode != 1'b0) begin
        cyc = 0; a_rw = 0; a_we = 0; a_as = 0; a_rq = 0;
        a_ir = 0; a_pc = 0; a_fl = 0; nret = 0;
      end else begin
        cyc++;
        a_rw += int'(reg_write);
        a_we += int'(mif.mem_req && mif.mem_we);
        a_as += int'(mif.mem_req && mif.mem_addr_sel);
        a_rq += int'(mif.mem_req);
        a_ir += int'(ir_write);
        a_pc += int'(pc_write);
        a_fl |= fault;
        if (retired) begin
          chk("retire_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("latency", cyc, e.lat);
            chk("reg_write_cnt", a_rw, e.rw);
            chk("mem_we_cnt", a_we, e.we);
            chk("addr_sel_cnt", a_as, e.asel);
            chk("mem_req_cnt", a_rq, e.req);
            chk("ir_write_cnt", a_ir, 1);
            chk("pc_write_cnt", a_pc, 1);
            chk("fault_seen", a_fl, 0);
            chk("retire_count", retire_count, nret);
          end
          nret++;
          cyc = 0; a_rw = 0; a_we = 0; a_as = 0; a_rq = 0;
          a_ir = 0; a_pc = 0; a_fl = 0;
        end
      end
    end
  end

  initial begin
    int t;
    int seq[4];
    bit bad;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG,
            OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH};
    seq = '{0, 1, 2, 4};

    // Randomized instruction stream against the scoreboard.
    for (int i = 0; i < N; i++) begin
      logic [6:0] o;
      int fw, mw;
      o  = ops[$urandom_range(0, 8)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      opq.push_back(o);
      waitq.push_back(fw);
      if (o == OP_LOAD || o == OP_STORE)
        waitq.push_back(mw);
      sb.push_back(model(o, fw, mw));
    end
    mode = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_count", retire_count, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mem_req", mif.mem_req, 1);
    t = 0;
    while (sb.size() > 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
    chk("final_retire_count", retire_count, N);

    // Directed REG stream with zero-wait memory.
    mode = 1'b1;
    op_man = OP_REG;
    do_reset();
    mr_man = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("reg_seq_state", state, seq[i % 4]);
      chk("reg_seq_retired", retired, (i % 4) == 3);
    end
    @(negedge clk);
    chk("reg_seq_count", retire_count, 3);

    // Illegal opcode trap and sticky hold.
    do_reset();
    op_man = 7'd0;
    mr_man = 1'b1;
    @(negedge clk);
    chk("ill_ir_write", ir_write, 1);
    @(posedge clk);
    #1 mr_man = 1'b0;
    @(negedge clk);
    chk("ill_decode", state, 1);
    @(negedge clk);
    chk("ill_state", state, 5);
    chk("ill_fault", fault, 1);
    chk("ill_cause", fault_cause, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      mr_man = 1'($urandom);
      op_man = 7'($urandom);
      @(negedge clk);
      if (state != 3'd5 || !fault || mif.mem_req ||
          ir_write || pc_write || reg_write || retired ||
          fault_cause != 2'd1)
        bad = 1;
    end
    chk("fault_hold", bad, 0);
    do_reset();
    @(negedge clk);
    chk("clr_state", state, 0);
    chk("clr_cause", fault_cause, 0);
    chk("clr_fault", fault, 0);

    // Fetch timeout after 16 unanswered cycles.
    op_man = OP_REG;
    do_reset();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (state != 3'd0 || !mif.mem_req) bad = 1;
    end
    chk("to_waiting", bad, 0);
    @(negedge clk);
    chk("to_state", state, 5);
    chk("to_cause", fault_cause, 2);

    // Ready on the 16th cycle still succeeds.
    do_reset();
    repeat (15) @(posedge clk);
    #1 mr_man = 1'b1;
    @(negedge clk);
    chk("last_ir_write", ir_write, 1);
    @(posedge clk);
    #1 mr_man = 1'b0;
    @(negedge clk);
    chk("last_state", state, 1);
    chk("last_cause", fault_cause, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
